// File: rtl/serial_shift_ctrl_pkg.sv
// Shared definitions for the serial_shift_ctrl block.
//   - FSM state encoding (IDLE / SHIFT)
//   - cnt_width(): width of the per-word bit counter for a given word length
package serial_shift_ctrl_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_SHIFT = 1'b1;

    typedef enum logic {
        StIdle  = ST_IDLE,
        StShift = ST_SHIFT
    } state_e;

    // Bit counter must index 0..width-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_shift_register.sv
// Parallel-load, serial-out shift register (MSB first).
// Ports:
//   clk      - rising-edge clock
//   rst      - synchronous active-high reset, clears the register
//   load     - capture din (has priority over shift)
//   shift    - shift left by one, zero fill
//   din      - parallel word
//   dout_msb - current MSB of the register
module piso_shift_register #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             dout_msb
);

    logic [WIDTH-1:0] shreg_q, shreg_d;

    always_comb begin
        shreg_d = shreg_q;
        if (load) begin
            shreg_d = din;
        end else if (shift) begin
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign dout_msb = shreg_q[WIDTH-1];

endmodule

// File: rtl/serial_shift_ctrl.sv
// Serialiser controller: accepts WIDTH-bit words over valid/ready and emits them
// MSB-first, one bit per accepted output cycle, with a last-bit marker.
// Back-to-back words are reloaded on the last bit's cycle so there is no bubble.
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   in_data/valid/ready  - word input handshake
//   out_bit/valid/ready  - serial bit output handshake
//   out_last             - out_bit is bit 0 of the current word
//   busy                 - a frame is in flight
//   frames_sent          - wrapping count of fully transmitted words
module serial_shift_ctrl
    import serial_shift_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_bit,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready,
    output logic             busy,
    output logic [CNT_W-1:0] frames_sent
);

    localparam int unsigned   CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] frames_q, frames_d;

    logic in_fire;
    logic out_fire;

    assign out_valid   = (state_q == StShift);
    assign busy        = out_valid;
    assign out_last    = out_valid & (cnt_q == LAST_IDX);
    assign in_ready    = (state_q == StIdle) | (out_last & out_ready);
    assign in_fire     = in_valid & in_ready;
    assign out_fire    = out_valid & out_ready;
    assign frames_sent = frames_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        frames_d = frames_q;
        unique case (state_q)
            StIdle: begin
                if (in_fire) begin
                    state_d = StShift;
                    cnt_d   = '0;
                end
            end
            StShift: begin
                if (out_fire) begin
                    if (!out_last) begin
                        cnt_d = cnt_q + 1'b1;
                    end else begin
                        frames_d = frames_q + 1'b1;
                        if (in_fire) begin
                            cnt_d = '0;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            frames_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            frames_q <= frames_d;
        end
    end

    // Shifting on every accepted bit also clears the register after the last bit:
    // by then only the old bit 0 remains at the MSB, so one more shift leaves zero.
    // A reload in the same cycle wins because load has priority.
    piso_shift_register #(
        .WIDTH (WIDTH)
    ) u_piso (
        .clk      (clk),
        .rst      (rst),
        .load     (in_fire),
        .shift    (out_fire),
        .din      (in_data),
        .dout_msb (out_bit)
    );

endmodule

// File: tb/tb_serial_shift_ctrl.sv
module tb_serial_shift_ctrl;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             out_bit;
    logic             out_valid;
    logic             out_last;
    logic             out_ready;
    logic             busy;
    logic [CNT_W-1:0] frames_sent;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    // Reference model: bits still owed for the accepted words, oldest first,
    // plus the number of completed words modulo 2^CNT_W.
    bit          exp_q[$];
    int unsigned frames_m = 0;

    serial_shift_ctrl #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_bit     (out_bit),
        .out_valid   (out_valid),
        .out_last    (out_last),
        .out_ready   (out_ready),
        .busy        (busy),
        .frames_sent (frames_sent)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        bit exp_valid, exp_last, exp_rdy, exp_bit;
        if (rst) begin
            exp_q.delete();
            frames_m = 0;
        end else begin
            exp_valid = (exp_q.size() != 0);
            exp_last  = (exp_q.size() == 1);
            exp_rdy   = !exp_valid || (exp_last && out_ready);
            exp_bit   = exp_valid ? exp_q[0] : 1'b0;
            check("out_valid", 32'(out_valid), 32'(exp_valid));
            check("busy", 32'(busy), 32'(exp_valid));
            check("out_last", 32'(out_last), 32'(exp_last));
            check("in_ready", 32'(in_ready), 32'(exp_rdy));
            check("out_bit", 32'(out_bit), 32'(exp_bit));
            check("frames_sent", 32'(frames_sent), frames_m);
            if (exp_valid && out_ready) begin
                void'(exp_q.pop_front());
                if (exp_last) frames_m = (frames_m + 1) % (1 << CNT_W);
            end
            if (in_valid && exp_rdy) begin
                for (int i = WIDTH - 1; i >= 0; i--) begin
                    exp_q.push_back(bit'((int'(in_data) >> i) & 1));
                end
            end
        end
    end

    // Offer a word and hold it until the controller takes it.
    task automatic send(input logic [WIDTH-1:0] w, input bit rnd);
        bit ok = 1'b0;
        in_data  = w;
        in_valid = 1'b1;
        if (rnd) out_ready = 1'($urandom_range(0, 1));
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            if (rnd) out_ready = 1'($urandom_range(0, 1));
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("send_accepted", 32'(ok), 32'd1);
    endtask

    // Wait until the model has no bits outstanding.
    task automatic drain(input bit rnd);
        bit ok = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            if (rnd) out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
        check("drain_done", 32'(ok), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;

        // Reset, then idle.
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        // Single word.
        send(4'b1011, 1'b0);
        drain(1'b0);
        check("frames_single", 32'(frames_sent), 32'd1);

        // Back-to-back words, no gap.
        do_reset();
        send(4'b1100, 1'b0);
        send(4'b0011, 1'b0);
        drain(1'b0);
        check("frames_b2b", 32'(frames_sent), 32'd2);

        // Back-pressure after the second bit.
        do_reset();
        send(4'b1001, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain(1'b0);
        check("frames_stall", 32'(frames_sent), 32'd1);

        // Reset mid-frame, then a fresh word.
        do_reset();
        send(4'b1111, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        check("frames_after_rst", 32'(frames_sent), 32'd0);
        send(4'b0101, 1'b0);
        drain(1'b0);

        // Random words with random back-pressure; counter wraps 1,2,3,0,1.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            send(WIDTH'($urandom), 1'b1);
        end
        drain(1'b1);
        check("frames_wrap", 32'(frames_sent), 32'd1);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/serial_shift_ctrl.md
Name: serial_shift_ctrl

Overview:
- Controller that sequences a parallel-load, serial-out (PISO) shift-register datapath.
- Accepts WIDTH-bit words over a valid/ready handshake and emits them MSB-first, one bit per accepted cycle, with valid/ready flow control and a last-bit marker.
- Sits between a word producer and a bit-serial consumer (serial link, LED driver).
- Supports back-to-back frames with no bubble cycle.

Parameters:
- WIDTH, 4, word length in bits; legal range 2..32.
- CNT_W, 8, width of the wrapping frame counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  parallel word to serialise.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  controller accepts a word this cycle.
- out_bit  output  1  current serial bit (MSB of the datapath register).
- out_valid  output  1  out_bit is valid.
- out_last  output  1  out_bit is bit 0 of the current word.
- out_ready  input  1  consumer accepts out_bit this cycle.
- busy  output  1  high while a frame is in flight (state SHIFT).
- frames_sent  output  CNT_W  count of fully transmitted words, wraps modulo 2^CNT_W.

Behaviour:
- States: IDLE, SHIFT. All state, counters and the shift register update only on posedge clk.
- Reset (rst=1 at a clock edge) has priority over everything. Next cycle:
  - state=IDLE, bit counter=0, shift register=0, frames_sent=0.
  - out_bit=0, out_valid=0, out_last=0, busy=0, in_ready=1.
  - A word or frame in progress is discarded. No partial frame resumes after reset.
- Derived signals:
  - out_fire = out_valid & out_ready.
  - in_fire = in_valid & in_ready.
- in_ready (combinational) = (state==IDLE) | (state==SHIFT & out_last & out_ready).
- out_valid = (state==SHIFT). busy = out_valid.
- out_bit = shreg[WIDTH-1]. out_last = out_valid & (cnt==WIDTH-1).
- IDLE:
  - On in_fire: shreg<=in_data, cnt<=0, state<=SHIFT.
  - The first bit (in_data[WIDTH-1]) is visible on out_bit the following cycle. Latency from accept to first valid bit is 1 cycle.
- SHIFT with out_ready=0:
  - shreg, cnt and state hold. out_bit, out_valid and out_last stay stable (valid must not drop while stalled).
- SHIFT with out_fire and cnt<WIDTH-1:
  - shreg<={shreg[WIDTH-2:0],1'b0}, cnt<=cnt+1.
- SHIFT with out_fire and cnt==WIDTH-1 (last bit):
  - frames_sent<=frames_sent+1 (wraps).
  - If in_fire the same cycle: load the new word, cnt<=0, remain in SHIFT. The next cycle shows the new word's MSB, with no gap.
  - Otherwise: shreg<=0, state<=IDLE.
- in_valid while SHIFT and not on the last accepted bit: in_ready=0, so the word is not taken. The producer must hold it.
- A full word of WIDTH bits takes exactly WIDTH out_fire cycles from first bit to IDLE or reload.
- frames_sent wraps from 2^CNT_W-1 to 0 with no flag.
- No combinational path from in_data to out_bit.

Decomposition:
- Shared package/include holds:
  - state encoding localparams: ST_IDLE=1'b0, ST_SHIFT=1'b1;
  - the counter-width helper, $clog2(WIDTH).
- One sub-module, piso_shift_register:
  - ports: clk, rst, load, shift, din[WIDTH], dout_msb;
  - synchronous reset to 0; load has priority over shift.
- Controller holds the FSM, bit counter, frame counter and handshake logic.

Test Plan:
1. Reset, then idle: assert rst 2 cycles, release with in_valid=0 for 5 cycles -> out_valid=0, out_bit=0, busy=0, in_ready=1, frames_sent=0 every cycle.
2. Single word, WIDTH=4, out_ready=1: send in_data=4'b1011 -> next 4 cycles out_bit=1,0,1,1 with out_valid=1 and out_last only on the 4th. Then IDLE with out_valid=0 and frames_sent=1.
3. Back-to-back: 4'b1100 then 4'b0011, in_valid held high, out_ready=1 -> 8 consecutive valid bits 1,1,0,0,0,0,1,1 with no gap. in_ready=1 only on each last-bit cycle. frames_sent=2.
4. Back-pressure: send 4'b1001, drop out_ready for 3 cycles after the 2nd bit -> out_bit stays 0 and out_valid stays 1 during the stall. Remaining bits 0,1 follow after out_ready returns. Total 4 bits delivered.
5. Reset mid-frame: load 4'b1111, assert rst after 2 bits -> next cycle out_valid=0, out_bit=0, frames_sent=0. A subsequent 4'b0101 serialises as 0,1,0,1.
6. Counter wrap (CNT_W=2) plus random: 5 random words with random out_ready -> each bit matches the MSB-first reference model. frames_sent sequence 1,2,3,0,1.
